// File: rtl/addsubt_arbiter.sv
// Round-robin arbiter sharing one FP add/subtract unit among channels X, Y, Z.
// Operands are latched at grant; the unit handshake is Begin_SUM out, ACK_ADD_SUBT back.
module addsubt_arbiter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         REQ_X,
    input  logic         REQ_Y,
    input  logic         REQ_Z,
    input  logic [W-1:0] OPA_X,
    input  logic [W-1:0] OPA_Y,
    input  logic [W-1:0] OPA_Z,
    input  logic [W-1:0] OPB_X,
    input  logic [W-1:0] OPB_Y,
    input  logic [W-1:0] OPB_Z,
    input  logic         OP_X,
    input  logic         OP_Y,
    input  logic         OP_Z,
    output logic         ACK_X,
    output logic         ACK_Y,
    output logic         ACK_Z,
    output logic [W-1:0] RESULT,
    output logic [2:0]   GNT,
    output logic         BUSY,
    output logic         Begin_SUM,
    output logic         ADD_SUBT,
    output logic [W-1:0] DATA_A,
    output logic [W-1:0] DATA_B,
    input  logic         ACK_ADD_SUBT,
    input  logic [W-1:0] DATA_RES
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t       state_q;
    logic [1:0]   pri_q;
    logic [2:0]   gnt_q;
    logic [2:0]   ack_q;
    logic         busy_q;
    logic         begin_q;
    logic         addsubt_q;
    logic [W-1:0] data_a_q;
    logic [W-1:0] data_b_q;
    logic [W-1:0] result_q;

    logic [3:0]   req;
    logic         win_vld_d;
    logic [1:0]   win_idx_d;
    logic [2:0]   gnt_d;
    logic [W-1:0] opa_d;
    logic [W-1:0] opb_d;
    logic         op_d;
    logic [1:0]   c0, c1, c2;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign req = {1'b0, REQ_Z, REQ_Y, REQ_X};
    assign c0  = pri_q;
    assign c1  = inc3(c0);
    assign c2  = inc3(c1);

    // Later candidates are overridden by earlier ones, so c0 (PRI) wins ties.
    always_comb begin
        win_vld_d = 1'b0;
        win_idx_d = 2'd0;
        if (req[c2]) begin win_vld_d = 1'b1; win_idx_d = c2; end
        if (req[c1]) begin win_vld_d = 1'b1; win_idx_d = c1; end
        if (req[c0]) begin win_vld_d = 1'b1; win_idx_d = c0; end
    end

    always_comb begin
        gnt_d = 3'b000;
        opa_d = OPA_X;
        opb_d = OPB_X;
        op_d  = OP_X;
        case (win_idx_d)
            2'd0: begin gnt_d = 3'b001; opa_d = OPA_X; opb_d = OPB_X; op_d = OP_X; end
            2'd1: begin gnt_d = 3'b010; opa_d = OPA_Y; opb_d = OPB_Y; op_d = OP_Y; end
            2'd2: begin gnt_d = 3'b100; opa_d = OPA_Z; opb_d = OPB_Z; op_d = OP_Z; end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            pri_q     <= 2'd0;
            gnt_q     <= 3'b000;
            ack_q     <= 3'b000;
            busy_q    <= 1'b0;
            begin_q   <= 1'b0;
            addsubt_q <= 1'b0;
            data_a_q  <= '0;
            data_b_q  <= '0;
            result_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (win_vld_d) begin
                    data_a_q  <= opa_d;
                    data_b_q  <= opb_d;
                    addsubt_q <= op_d;
                    gnt_q     <= gnt_d;
                    pri_q     <= inc3(win_idx_d);
                    busy_q    <= 1'b1;
                    begin_q   <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    begin_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: if (ACK_ADD_SUBT) begin
                    result_q <= DATA_RES;
                    ack_q    <= gnt_q;
                    state_q  <= DONE;
                end
                DONE: begin
                    ack_q   <= 3'b000;
                    gnt_q   <= 3'b000;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ACK_X     = ack_q[0];
    assign ACK_Y     = ack_q[1];
    assign ACK_Z     = ack_q[2];
    assign RESULT    = result_q;
    assign GNT       = gnt_q;
    assign BUSY      = busy_q;
    assign Begin_SUM = begin_q;
    assign ADD_SUBT  = addsubt_q;
    assign DATA_A    = data_a_q;
    assign DATA_B    = data_b_q;

endmodule

// File: tb/tb_addsubt_arbiter.sv
// Directed bench for addsubt_arbiter; the shared FP unit is played by hand-driven
// ACK_ADD_SUBT / DATA_RES with precomputed IEEE-754 results.
module tb_addsubt_arbiter;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST;
    logic         REQ_X, REQ_Y, REQ_Z;
    logic [W-1:0] OPA_X, OPA_Y, OPA_Z, OPB_X, OPB_Y, OPB_Z;
    logic         OP_X, OP_Y, OP_Z;
    logic         ACK_X, ACK_Y, ACK_Z;
    logic [W-1:0] RESULT;
    logic [2:0]   GNT;
    logic         BUSY, Begin_SUM, ADD_SUBT;
    logic [W-1:0] DATA_A, DATA_B;
    logic         ACK_ADD_SUBT;
    logic [W-1:0] DATA_RES;

    int total  = 0;
    int passed = 0;

    always #5 CLK = ~CLK;

    addsubt_arbiter #(.W(W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_X(REQ_X), .REQ_Y(REQ_Y), .REQ_Z(REQ_Z),
        .OPA_X(OPA_X), .OPA_Y(OPA_Y), .OPA_Z(OPA_Z),
        .OPB_X(OPB_X), .OPB_Y(OPB_Y), .OPB_Z(OPB_Z),
        .OP_X(OP_X), .OP_Y(OP_Y), .OP_Z(OP_Z),
        .ACK_X(ACK_X), .ACK_Y(ACK_Y), .ACK_Z(ACK_Z),
        .RESULT(RESULT), .GNT(GNT), .BUSY(BUSY),
        .Begin_SUM(Begin_SUM), .ADD_SUBT(ADD_SUBT),
        .DATA_A(DATA_A), .DATA_B(DATA_B),
        .ACK_ADD_SUBT(ACK_ADD_SUBT), .DATA_RES(DATA_RES)
    );

    // Advance one clock; outputs are observed 1 time unit after the rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One full transaction from IDLE with the unit acking at n=2; drop clears
    // the served channel's REQ at the edge that samples its ACK.
    task automatic serve(input string tag, input logic [2:0] eg, input logic [31:0] ea,
                         input logic [31:0] eb, input logic eop, input logic [31:0] res,
                         input logic [2:0] drop);
        step();
        chk({tag, ".gnt"},   {29'd0, GNT}, {29'd0, eg});
        chk({tag, ".begin"}, {31'd0, Begin_SUM}, 32'd1);
        chk({tag, ".busy"},  {31'd0, BUSY}, 32'd1);
        chk({tag, ".da"},    DATA_A, ea);
        chk({tag, ".db"},    DATA_B, eb);
        chk({tag, ".op"},    {31'd0, ADD_SUBT}, {31'd0, eop});
        step();
        chk({tag, ".begin_off"}, {31'd0, Begin_SUM}, 32'd0);
        chk({tag, ".gnt_wait"},  {29'd0, GNT}, {29'd0, eg});
        ACK_ADD_SUBT = 1'b1;
        DATA_RES     = res;
        step();
        ACK_ADD_SUBT = 1'b0;
        DATA_RES     = 32'h0;
        chk({tag, ".ack"},    {29'd0, ACK_Z, ACK_Y, ACK_X}, {29'd0, eg});
        chk({tag, ".result"}, RESULT, res);
        chk({tag, ".gnt_done"}, {29'd0, GNT}, {29'd0, eg});
        if (drop[0]) REQ_X = 1'b0;
        if (drop[1]) REQ_Y = 1'b0;
        if (drop[2]) REQ_Z = 1'b0;
        step();
        chk({tag, ".ack_off"}, {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd0);
        chk({tag, ".gnt_off"}, {29'd0, GNT}, 32'd0);
        chk({tag, ".idle"},    {31'd0, BUSY}, 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        REQ_X = 0; REQ_Y = 0; REQ_Z = 0;
        OPA_X = 32'h3F800000; OPB_X = 32'h40000000; OP_X = 1'b0;  // 1 + 2 = 3
        OPA_Y = 32'h41200000; OPB_Y = 32'h40000000; OP_Y = 1'b1;  // 10 - 2 = 8
        OPA_Z = 32'h40A00000; OPB_Z = 32'h3F800000; OP_Z = 1'b1;  // 5 - 1 = 4
        ACK_ADD_SUBT = 1'b0;
        DATA_RES = 32'h0;

        // Reset state
        step(); step();
        chk("rst.gnt",    {29'd0, GNT}, 32'd0);
        chk("rst.busy",   {31'd0, BUSY}, 32'd0);
        chk("rst.begin",  {31'd0, Begin_SUM}, 32'd0);
        chk("rst.ack",    {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd0);
        chk("rst.result", RESULT, 32'd0);
        chk("rst.da",     DATA_A, 32'd0);
        RST = 1'b0;
        step();

        // Single X transaction, unit acks 3 cycles after Begin_SUM
        REQ_X = 1'b1;
        step();
        chk("single.gnt",   {29'd0, GNT}, 32'd1);
        chk("single.begin", {31'd0, Begin_SUM}, 32'd1);
        chk("single.da",    DATA_A, 32'h3F800000);
        chk("single.db",    DATA_B, 32'h40000000);
        chk("single.op",    {31'd0, ADD_SUBT}, 32'd0);
        step();
        chk("single.begin_once", {31'd0, Begin_SUM}, 32'd0);
        step();
        chk("single.noack_early", {31'd0, ACK_X}, 32'd0);
        ACK_ADD_SUBT = 1'b1;
        DATA_RES = 32'h40400000;
        step();
        ACK_ADD_SUBT = 1'b0;
        REQ_X = 1'b0;
        chk("single.ack",    {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd1);
        chk("single.result", RESULT, 32'h40400000);
        step();
        chk("single.ack_off", {31'd0, ACK_X}, 32'd0);
        chk("single.gnt_off", {29'd0, GNT}, 32'd0);

        // Rotation: PRI=1 after X, so Z beats X with Y idle
        REQ_X = 1'b1; REQ_Z = 1'b1;
        serve("rot.z", 3'b100, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 3'b100);
        serve("rot.x", 3'b001, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b001);

        // Reset wins over simultaneous requests, then round-robin from PRI=0
        RST = 1'b1; REQ_X = 1'b1; REQ_Y = 1'b1; REQ_Z = 1'b1;
        step();
        chk("rstpri.gnt",  {29'd0, GNT}, 32'd0);
        chk("rstpri.busy", {31'd0, BUSY}, 32'd0);
        RST = 1'b0;
        serve("rr.x1", 3'b001, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b000);
        serve("rr.y",  3'b010, 32'h41200000, 32'h40000000, 1'b1, 32'h41000000, 3'b000);
        serve("rr.z",  3'b100, 32'h40A00000, 32'h3F800000, 1'b1, 32'h40800000, 3'b000);
        serve("rr.x2", 3'b001, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3'b111);

        // Abort: reset in WAIT, late unit ack must be ignored
        REQ_Y = 1'b1;
        step();
        chk("abort.gnt", {29'd0, GNT}, 32'd2);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        REQ_Y = 1'b0;
        chk("abort.gnt0",   {29'd0, GNT}, 32'd0);
        chk("abort.busy0",  {31'd0, BUSY}, 32'd0);
        chk("abort.da0",    DATA_A, 32'd0);
        chk("abort.res0",   RESULT, 32'd0);
        step();
        ACK_ADD_SUBT = 1'b1;
        DATA_RES = 32'hDEADBEEF;
        step();
        ACK_ADD_SUBT = 1'b0;
        DATA_RES = 32'h0;
        chk("abort.noack", {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd0);
        step();
        chk("abort.noack2", {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd0);
        chk("abort.res",    RESULT, 32'd0);
        chk("abort.idle",   {31'd0, BUSY}, 32'd0);
        REQ_Y = 1'b1;
        serve("abort.y", 3'b010, 32'h41200000, 32'h40000000, 1'b1, 32'h41000000, 3'b010);

        // Robustness: operand change and REQ drop in WAIT, unit ack held 3 cycles
        REQ_Y = 1'b1;
        step();
        chk("rob.gnt", {29'd0, GNT}, 32'd2);
        step();
        OPA_Y = 32'hC0000000;
        REQ_Y = 1'b0;
        step();
        chk("rob.da_wait", DATA_A, 32'h41200000);
        ACK_ADD_SUBT = 1'b1;
        DATA_RES = 32'h41000000;
        step();
        chk("rob.ack",  {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd2);
        chk("rob.res",  RESULT, 32'h41000000);
        step();
        chk("rob.ack_once", {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd0);
        step();
        ACK_ADD_SUBT = 1'b0;
        chk("rob.ack_once2", {29'd0, ACK_Z, ACK_Y, ACK_X}, 32'd0);
        chk("rob.idle",      {31'd0, BUSY}, 32'd0);
        step();
        chk("rob.da_kept", DATA_A, 32'h41200000);
        chk("rob.gnt_off", {29'd0, GNT}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
